// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences machine-mode interrupt entry (mepc, mcause, mstatus
// writes then PC redirect) and MRET return (mstatus write then redirect).
// In IDLE the pipeline's CSR write port passes straight through. While a
// sequence runs, the controller owns the CSR write port instead.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic [31:0] mie_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] pc_ex,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        is_mret,
  input  logic        pipe_csr_we,
  input  logic [11:0] pipe_csr_addr,
  input  logic [31:0] pipe_csr_wdata,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        flush,
  output logic        stall_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STATUS, M_STATUS, REDIR
  } state_t;

  state_t      state_q;
  logic [31:0] epc_q, cause_q, mstatus_q, target_q;

  // Registered Moore outputs for the non-IDLE states.
  logic        csr_we_q, flush_q, stall_q, redir_valid_q;
  logic [11:0] csr_addr_q;
  logic [31:0] csr_wdata_q, redir_pc_q;

  logic        irq_take_d, mret_take_d, accept_d;
  logic [31:0] cause_d, base_d, target_d, trap_status_d, mret_status_d;

  // Acceptance decision and values to capture at acceptance.
  always_comb begin
    irq_take_d  = (state_q == IDLE) & mstatus_i[3] &
                  ((irq_ext & mie_i[11]) | (irq_timer & mie_i[7])) &
                  ex_valid & ~ex_stall;
    mret_take_d = (state_q == IDLE) & is_mret & ex_valid & ~ex_stall & ~irq_take_d;
    accept_d    = irq_take_d | mret_take_d;
    // External interrupt has priority over timer.
    cause_d     = (irq_ext & mie_i[11]) ? CAUSE_EXT : CAUSE_TIMER;
    base_d      = {mtvec_i[31:2], 2'b00};
    if (VECTORED_EN && (mtvec_i[1:0] == 2'b01))
      target_d = base_d + {26'd0, cause_d[3:0], 2'b00};
    else
      target_d = base_d;
    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M (computed from the latched copy).
    trap_status_d        = mstatus_q;
    trap_status_d[7]     = mstatus_q[3];
    trap_status_d[3]     = 1'b0;
    trap_status_d[12:11] = 2'b11;
    // Return: MIE <= MPIE, MPIE <= 1 (from the value latched at MRET acceptance).
    mret_status_d        = mstatus_q;
    mret_status_d[3]     = mstatus_q[7];
    mret_status_d[7]     = 1'b1;
  end

  // Sequencer: state, latched context and next-cycle registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      epc_q         <= '0;
      cause_q       <= '0;
      mstatus_q     <= '0;
      target_q      <= '0;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      flush_q       <= 1'b0;
      stall_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      flush_q       <= 1'b0;
      stall_q       <= 1'b1;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      case (state_q)
        IDLE: begin
          if (irq_take_d) begin
            epc_q       <= pc_ex;
            cause_q     <= cause_d;
            mstatus_q   <= mstatus_i;
            target_q    <= target_d;
            state_q     <= T_EPC;
            csr_we_q    <= 1'b1;
            csr_addr_q  <= ADDR_MEPC;
            csr_wdata_q <= pc_ex;
            flush_q     <= 1'b1;
          end else if (mret_take_d) begin
            mstatus_q   <= mstatus_i;
            target_q    <= mepc_i;
            state_q     <= M_STATUS;
            csr_we_q    <= 1'b1;
            csr_addr_q  <= ADDR_MSTATUS;
            // Same MRET update as mret_status_d, but from the live input.
            csr_wdata_q <= {mstatus_i[31:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
            flush_q     <= 1'b1;
          end else begin
            stall_q     <= 1'b0;
          end
        end
        T_EPC: begin
          state_q     <= T_CAUSE;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= ADDR_MCAUSE;
          csr_wdata_q <= cause_q;
        end
        T_CAUSE: begin
          state_q     <= T_STATUS;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= ADDR_MSTATUS;
          csr_wdata_q <= trap_status_d;
        end
        T_STATUS, M_STATUS: begin
          state_q       <= REDIR;
          redir_valid_q <= 1'b1;
          redir_pc_q    <= target_q;
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // IDLE passes pipeline CSR writes through unless this cycle accepts a trap/mret.
  always_comb begin
    if (state_q == IDLE) begin
      csr_we    = pipe_csr_we & ~accept_d & ~reset;
      csr_addr  = csr_we ? pipe_csr_addr  : 12'd0;
      csr_wdata = csr_we ? pipe_csr_wdata : 32'd0;
    end else begin
      csr_we    = csr_we_q;
      csr_addr  = csr_addr_q;
      csr_wdata = csr_wdata_q;
    end
    flush          = flush_q;
    stall_o        = stall_q;
    redirect_valid = redir_valid_q;
    redirect_pc    = redir_pc_q;
  end

  logic unused_ok;
  assign unused_ok = ^{epc_q, mret_status_d};

endmodule
